// File: rtl/vga_timing_pkg.sv
// Shared raster-timing types, mode presets and segment helpers for vga_timing_gen.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } seg_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    int unsigned res_x;
    int unsigned hfp;
    int unsigned hpulse;
    int unsigned hbp;
    int unsigned res_y;
    int unsigned vfp;
    int unsigned vpulse;
    int unsigned vbp;
  } mode_t;

  function automatic int unsigned axis_total(input int unsigned act, fp, pulse, bp);
    return act + fp + pulse + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned act, fp);
    return act + fp;
  endfunction

  function automatic int unsigned back_first(input int unsigned act, fp, pulse);
    return act + fp + pulse;
  endfunction

  // Segment of a position along one axis: active, front porch, sync, back porch.
  function automatic seg_e seg_of(input int unsigned pos, act, fp, pulse);
    if (pos < act) return SEG_ACTIVE;
    if (pos < sync_first(act, fp)) return SEG_FRONT;
    if (pos < back_first(act, fp, pulse)) return SEG_SYNC;
    return SEG_BACK;
  endfunction

  localparam mode_t MODE_1024X768 = '{
    res_x: 1024, hfp: 16, hpulse: 96, hbp: 44,
    res_y: 768,  vfp: 10, vpulse: 2,  vbp: 31
  };

  localparam mode_t MODE_640X480 = '{
    res_x: 640, hfp: 16, hpulse: 96, hbp: 48,
    res_y: 480, vfp: 10, vpulse: 2,  vbp: 33
  };

  localparam int unsigned HTOTAL_1024X768 = axis_total(1024, 16, 96, 44);
  localparam int unsigned VTOTAL_1024X768 = axis_total(768, 10, 2, 31);
  localparam int unsigned HTOTAL_640X480  = axis_total(640, 16, 96, 48);
  localparam int unsigned VTOTAL_640X480  = axis_total(480, 10, 2, 33);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing-generator output bundle plus pixel enable; master = generator, slave = consumer.
interface vga_timing_gen_if #(
  parameter int unsigned C_bits_x     = 11,
  parameter int unsigned C_bits_y     = 11,
  parameter int unsigned C_frame_bits = 8
);
  logic                    ce;
  logic [C_bits_x-1:0]     x;
  logic [C_bits_y-1:0]     y;
  logic                    hsync;
  logic                    vsync;
  logic                    blank;
  logic [C_bits_x-1:0]     fetch_x;
  logic [C_bits_y-1:0]     fetch_y;
  logic                    fetch_active;
  logic                    line_start;
  logic                    frame_start;
  logic [C_frame_bits-1:0] frame_count;
  logic [7:0]              test_r;
  logic [7:0]              test_g;
  logic [7:0]              test_b;

  modport master (
    input  ce,
    output x, y, hsync, vsync, blank,
    output fetch_x, fetch_y, fetch_active,
    output line_start, frame_start, frame_count,
    output test_r, test_g, test_b
  );

  modport slave (
    output ce,
    input  x, y, hsync, vsync, blank,
    input  fetch_x, fetch_y, fetch_active,
    input  line_start, frame_start, frame_count,
    input  test_r, test_g, test_b
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered segment decode aligned to it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_bits   = 11,
  parameter int unsigned C_active = 1024,
  parameter int unsigned C_fp     = 16,
  parameter int unsigned C_pulse  = 96,
  parameter int unsigned C_bp     = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [C_bits-1:0] count,
  output seg_e              seg,
  output logic              last_c
);

  localparam int unsigned       TOTAL = axis_total(C_active, C_fp, C_pulse, C_bp);
  localparam logic [C_bits-1:0] LAST  = C_bits'(TOTAL - 1);

  logic [C_bits-1:0] count_next;
  seg_e              seg_next;

  assign last_c = (count == LAST);

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = last_c ? '0 : count + C_bits'(1);
    end
    seg_next = seg_of(32'(count_next), C_active, C_fp, C_pulse);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      seg   <= SEG_ACTIVE;
    end else begin
      count <= count_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with sync polarity, pixel enable, prefetch stream and strobes.
// Optional test picture on test_r/g/b when VGA_TIMING_TEST_PICTURE_EN is defined; otherwise tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_resolution_x      = MODE_1024X768.res_x,
  parameter int unsigned C_hsync_front_porch = MODE_1024X768.hfp,
  parameter int unsigned C_hsync_pulse       = MODE_1024X768.hpulse,
  parameter int unsigned C_hsync_back_porch  = MODE_1024X768.hbp,
  parameter int unsigned C_resolution_y      = MODE_1024X768.res_y,
  parameter int unsigned C_vsync_front_porch = MODE_1024X768.vfp,
  parameter int unsigned C_vsync_pulse       = MODE_1024X768.vpulse,
  parameter int unsigned C_vsync_back_porch  = MODE_1024X768.vbp,
  parameter int unsigned C_bits_x            = 11,
  parameter int unsigned C_bits_y            = 11,
  parameter logic        C_hsync_polarity    = 1'b0,
  parameter logic        C_vsync_polarity    = 1'b0,
  parameter int unsigned C_prefetch          = 2,
  parameter int unsigned C_frame_bits        = 8
) (
  input  logic             clk_pixel,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int unsigned HTOTAL = axis_total(C_resolution_x, C_hsync_front_porch,
                                              C_hsync_pulse, C_hsync_back_porch);
  localparam int unsigned VTOTAL = axis_total(C_resolution_y, C_vsync_front_porch,
                                              C_vsync_pulse, C_vsync_back_porch);
  localparam int unsigned FBX    = C_bits_x + 1;

  localparam logic [FBX-1:0]      HTOTAL_W = FBX'(HTOTAL);
  localparam logic [FBX-1:0]      PREF_W   = FBX'(C_prefetch);
  localparam logic [C_bits_x-1:0] XRES     = C_bits_x'(C_resolution_x);
  localparam logic [C_bits_y-1:0] YRES     = C_bits_y'(C_resolution_y);
  localparam logic [C_bits_y-1:0] VLAST    = C_bits_y'(VTOTAL - 1);

  logic [C_bits_x-1:0]     hcount;
  logic [C_bits_y-1:0]     vcount;
  seg_e                    hseg;
  seg_e                    vseg;
  logic                    h_last;
  logic                    v_last;
  logic                    frame_wrap;
  logic [C_frame_bits-1:0] fc_next;
  logic                    blank_next;
  logic [FBX-1:0]          hf_sum;
  logic [C_bits_x-1:0]     hf;
  logic [C_bits_y-1:0]     vf;
  logic                    fetch_active_next;
  rgb_t                    pic;

  vga_axis_counter #(
    .C_bits   (C_bits_x),
    .C_active (C_resolution_x),
    .C_fp     (C_hsync_front_porch),
    .C_pulse  (C_hsync_pulse),
    .C_bp     (C_hsync_back_porch)
  ) u_hcount (
    .clk    (clk_pixel),
    .rst    (reset),
    .en     (vif.ce),
    .count  (hcount),
    .seg    (hseg),
    .last_c (h_last)
  );

  vga_axis_counter #(
    .C_bits   (C_bits_y),
    .C_active (C_resolution_y),
    .C_fp     (C_vsync_front_porch),
    .C_pulse  (C_vsync_pulse),
    .C_bp     (C_vsync_back_porch)
  ) u_vcount (
    .clk    (clk_pixel),
    .rst    (reset),
    .en     (vif.ce & h_last),
    .count  (vcount),
    .seg    (vseg),
    .last_c (v_last)
  );

  // Frame counter steps on the same edge the counters wrap back to (0,0).
  assign frame_wrap = vif.ce & h_last & v_last;
  assign fc_next    = frame_wrap ? vif.frame_count + C_frame_bits'(1) : vif.frame_count;
  assign blank_next = (hseg != SEG_ACTIVE) || (vseg != SEG_ACTIVE);

  // Lookahead coordinate; crossing the line end carries into the next (wrapping) line.
  always_comb begin
    hf_sum = {1'b0, hcount} + PREF_W;
    hf     = C_bits_x'(hf_sum);
    vf     = vcount;
    if (hf_sum >= HTOTAL_W) begin
      hf = C_bits_x'(hf_sum - HTOTAL_W);
      vf = (vcount == VLAST) ? '0 : vcount + C_bits_y'(1);
    end
    fetch_active_next = (hf < XRES) && (vf < YRES);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      vif.x            <= '0;
      vif.y            <= '0;
      vif.hsync        <= ~C_hsync_polarity;
      vif.vsync        <= ~C_vsync_polarity;
      vif.blank        <= 1'b1;
      vif.fetch_x      <= '0;
      vif.fetch_y      <= '0;
      vif.fetch_active <= 1'b0;
      vif.line_start   <= 1'b0;
      vif.frame_start  <= 1'b0;
      vif.frame_count  <= '0;
    end else begin
      // Strobes drop on any idle pixel so they never stretch under ce gating.
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
      if (vif.ce) begin
        vif.x            <= hcount;
        vif.y            <= vcount;
        vif.hsync        <= (hseg == SEG_SYNC) ? C_hsync_polarity : ~C_hsync_polarity;
        vif.vsync        <= (vseg == SEG_SYNC) ? C_vsync_polarity : ~C_vsync_polarity;
        vif.blank        <= blank_next;
        vif.fetch_x      <= hf;
        vif.fetch_y      <= vf;
        vif.fetch_active <= fetch_active_next;
        vif.line_start   <= (hcount == '0);
        vif.frame_start  <= (hcount == '0) && (vcount == '0);
        vif.frame_count  <= fc_next;
      end
    end
  end

`ifdef VGA_TIMING_TEST_PICTURE_EN
  localparam logic [C_bits_x-1:0] XLAST = C_bits_x'(C_resolution_x - 1);
  localparam logic [C_bits_y-1:0] YLAST = C_bits_y'(C_resolution_y - 1);

  rgb_t pic_next;
  logic border;

  assign border = (hcount == '0) || (hcount == XLAST) || (vcount == '0) || (vcount == YLAST);

  always_comb begin
    pic_next = '0;
    if (!blank_next) begin
      if (border) begin
        pic_next = '{r: 8'hff, g: 8'hff, b: 8'hff};
      end else begin
        pic_next = '{r: 8'(hcount), g: 8'(vcount), b: 8'(fc_next)};
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      pic <= '0;
    end else if (vif.ce) begin
      pic <= pic_next;
    end
  end
`else
  assign pic = '0;
`endif

  assign vif.test_r = pic.r;
  assign vif.test_g = pic.g;
  assign vif.test_b = pic.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 8x4 mode: raster model checked every cycle plus directed scenarios.
module tb_vga_timing_gen;

  localparam int X = 8, HFP = 2, HP = 3, HBP = 1;
  localparam int Y = 4, VFP = 1, VP = 2, VBP = 1;
  localparam int HT = X + HFP + HP + HBP;
  localparam int VT = Y + VFP + VP + VBP;
  localparam int BX = 6, BY = 6;

  typedef struct {
    int x, y, hs, vs, bl, fx, fy, fa, ls, fs, fc, tr, tg, tb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.C_bits_x(BX), .C_bits_y(BY), .C_frame_bits(8)) if0 ();
  vga_timing_gen_if #(.C_bits_x(BX), .C_bits_y(BY), .C_frame_bits(2)) if1 ();
  assign if0.ce = ce;
  assign if1.ce = ce;

  vga_timing_gen #(
    .C_resolution_x(X), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
    .C_resolution_y(Y), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
    .C_bits_x(BX), .C_bits_y(BY), .C_hsync_polarity(1'b0), .C_vsync_polarity(1'b0),
    .C_prefetch(2), .C_frame_bits(8)
  ) u0 (
    .clk_pixel(clk), .reset(reset), .vif(if0)
  );

  vga_timing_gen #(
    .C_resolution_x(X), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
    .C_resolution_y(Y), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
    .C_bits_x(BX), .C_bits_y(BY), .C_hsync_polarity(1'b1), .C_vsync_polarity(1'b1),
    .C_prefetch(0), .C_frame_bits(2)
  ) u1 (
    .clk_pixel(clk), .reset(reset), .vif(if1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
  endtask

  function automatic exp_t rst_exp(input int hpol, input int vpol);
    exp_t e;
    e = '{default: 0};
    e.bl = 1;
    e.hs = 1 - hpol;
    e.vs = 1 - vpol;
    return e;
  endfunction

  // Outputs for a raster position, straight from the segment/fetch rules.
  function automatic exp_t predict(input int h, input int v, input int fc, input int pf,
                                   input int hpol, input int vpol);
    exp_t e;
    int hf, vf;
    e.x  = h;
    e.y  = v;
    e.bl = (h >= X || v >= Y) ? 1 : 0;
    e.hs = (h >= X + HFP && h < X + HFP + HP) ? hpol : 1 - hpol;
    e.vs = (v >= Y + VFP && v < Y + VFP + VP) ? vpol : 1 - vpol;
    hf = h + pf;
    vf = v;
    if (hf >= HT) begin
      hf = hf - HT;
      vf = (v + 1) % VT;
    end
    e.fx = hf;
    e.fy = vf;
    e.fa = (hf < X && vf < Y) ? 1 : 0;
    e.ls = (h == 0) ? 1 : 0;
    e.fs = (h == 0 && v == 0) ? 1 : 0;
    e.fc = fc;
    e.tr = 0; e.tg = 0; e.tb = 0;
`ifdef VGA_TIMING_TEST_PICTURE_EN
    if (e.bl == 0) begin
      if (h == 0 || h == X - 1 || v == 0 || v == Y - 1) begin
        e.tr = 255; e.tg = 255; e.tb = 255;
      end else begin
        e.tr = h % 256; e.tg = v % 256; e.tb = fc % 256;
      end
    end
`endif
    return e;
  endfunction

  function automatic exp_t grab0();
    exp_t g;
    g.x = int'(if0.x); g.y = int'(if0.y); g.hs = int'(if0.hsync); g.vs = int'(if0.vsync);
    g.bl = int'(if0.blank); g.fx = int'(if0.fetch_x); g.fy = int'(if0.fetch_y);
    g.fa = int'(if0.fetch_active); g.ls = int'(if0.line_start); g.fs = int'(if0.frame_start);
    g.fc = int'(if0.frame_count); g.tr = int'(if0.test_r); g.tg = int'(if0.test_g);
    g.tb = int'(if0.test_b);
    return g;
  endfunction

  function automatic exp_t grab1();
    exp_t g;
    g.x = int'(if1.x); g.y = int'(if1.y); g.hs = int'(if1.hsync); g.vs = int'(if1.vsync);
    g.bl = int'(if1.blank); g.fx = int'(if1.fetch_x); g.fy = int'(if1.fetch_y);
    g.fa = int'(if1.fetch_active); g.ls = int'(if1.line_start); g.fs = int'(if1.frame_start);
    g.fc = int'(if1.frame_count); g.tr = int'(if1.test_r); g.tg = int'(if1.test_g);
    g.tb = int'(if1.test_b);
    return g;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".x"}, a.x, e.x);
    chk({tag, ".y"}, a.y, e.y);
    chk({tag, ".hsync"}, a.hs, e.hs);
    chk({tag, ".vsync"}, a.vs, e.vs);
    chk({tag, ".blank"}, a.bl, e.bl);
    chk({tag, ".fetch_x"}, a.fx, e.fx);
    chk({tag, ".fetch_y"}, a.fy, e.fy);
    chk({tag, ".fetch_active"}, a.fa, e.fa);
    chk({tag, ".line_start"}, a.ls, e.ls);
    chk({tag, ".frame_start"}, a.fs, e.fs);
    chk({tag, ".frame_count"}, a.fc, e.fc);
    chk({tag, ".test_r"}, a.tr, e.tr);
    chk({tag, ".test_g"}, a.tg, e.tg);
    chk({tag, ".test_b"}, a.tb, e.tb);
  endtask

  int   mh = 0, mv = 0, frames = 0;
  exp_t e0, e1;

  // Compare on the falling edge, then predict what the next rising edge will present.
  always @(negedge clk) begin
    if (reset) begin
      mh = 0; mv = 0; frames = 0;
      e0 = rst_exp(0, 0);
      e1 = rst_exp(1, 1);
    end
    cmp("u0", e0, grab0());
    cmp("u1", e1, grab1());
    if (!reset) begin
      if (if0.x == 6'd10) chk("pin_u0_hsync_x10", int'(if0.hsync), 0);
      if (if0.x == 6'd9)  chk("pin_u0_hsync_x9", int'(if0.hsync), 1);
      if (if1.x == 6'd12) chk("pin_u1_hsync_x12", int'(if1.hsync), 1);
      if (if0.x == 6'd8)  chk("pin_u0_blank_x8", int'(if0.blank), 1);
      if (if0.y == 6'd5)  chk("pin_u0_vsync_y5", int'(if0.vsync), 0);
      if (if0.y == 6'd4)  chk("pin_u0_vsync_y4", int'(if0.vsync), 1);
      if (if0.x == 6'd12 && if0.y == 6'd3) begin
        chk("pin_fetch_x_at_12_3", int'(if0.fetch_x), 0);
        chk("pin_fetch_y_at_12_3", int'(if0.fetch_y), 4);
        chk("pin_fetch_act_at_12_3", int'(if0.fetch_active), 0);
      end
      if (if0.x == 6'd13 && if0.y == 6'd7) begin
        chk("pin_fetch_x_at_13_7", int'(if0.fetch_x), 1);
        chk("pin_fetch_y_at_13_7", int'(if0.fetch_y), 0);
        chk("pin_fetch_act_at_13_7", int'(if0.fetch_active), 1);
      end
`ifdef VGA_TIMING_TEST_PICTURE_EN
      if (if0.x == 6'd3 && if0.y == 6'd2) begin
        chk("pin_pic_r_3_2", int'(if0.test_r), 3);
        chk("pin_pic_g_3_2", int'(if0.test_g), 2);
      end
      if (if0.x == 6'd0 && if0.y == 6'd1) begin
        chk("pin_pic_r_0_1", int'(if0.test_r), 255);
        chk("pin_pic_g_0_1", int'(if0.test_g), 255);
        chk("pin_pic_b_0_1", int'(if0.test_b), 255);
      end
      if (if0.x == 6'd9 && if0.y == 6'd0) begin
        chk("pin_pic_r_9_0", int'(if0.test_r), 0);
        chk("pin_pic_b_9_0", int'(if0.test_b), 0);
      end
`endif
      if (ce) begin
        if (mh == HT - 1 && mv == VT - 1) frames++;
        e0 = predict(mh, mv, frames % 256, 2, 0, 0);
        e1 = predict(mh, mv, frames % 4, 0, 1, 1);
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end else begin
        e0.ls = 0; e0.fs = 0;
        e1.ls = 0; e1.fs = 0;
      end
    end
  end

  task automatic wait_fs(input int which, input int budget, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #2;
      n++;
      seen = (which == 0) ? if0.frame_start : if1.frame_start;
    end
    if (!seen) fail_now("wait_frame_start");
  endtask

  initial begin
    int   n;
    int   last;
    logic prev;
    logic found;

    reset = 1'b1;
    ce    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_u0_blank", int'(if0.blank), 1);
    chk("rst_u0_hsync", int'(if0.hsync), 1);
    chk("rst_u1_hsync", int'(if1.hsync), 0);
    chk("rst_u1_vsync", int'(if1.vsync), 0);
    reset = 1'b0;
    ce    = 1'b1;

    wait_fs(0, 20, n);
    chk("first_fs_latency", n, 1);
    chk("first_ls", int'(if0.line_start), 1);
    wait_fs(0, 200, n);
    chk("frame_period", n, 112);

    // Half-rate pixel enable: line_start stays one clock wide, period doubles.
    prev = 1'b0;
    last = -1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #2;
      if (if0.line_start) begin
        chk("ls_width", int'(prev), 0);
        if (last >= 0) chk("ls_period", i - last, 28);
        last = i;
      end
      prev = if0.line_start;
      ce = ~ce;
    end
    ce = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #2;
      found = (if0.x == 6'd5 && if0.y == 6'd2);
    end
    if (!found) fail_now("wait_x5_y2");
    reset = 1'b1;
    #1;
    chk("midrst_x", int'(if0.x), 0);
    chk("midrst_y", int'(if0.y), 0);
    chk("midrst_blank", int'(if0.blank), 1);
    chk("midrst_u1_hsync", int'(if1.hsync), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_x", int'(if0.x), 0);
    chk("post_rst_y", int'(if0.y), 0);
    chk("post_rst_fs", int'(if0.frame_start), 1);
    chk("post_rst_fc", int'(if0.frame_count), 0);

    for (int i = 0; i < 5; i++) begin
      wait_fs(1, 130, n);
      chk("fc_seq", int'(if1.frame_count), (i + 1) % 4);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator, clocked by the pixel clock.
- Supersedes the fixed 1024x768 timing block that feeds vga2dvid.
- Adds the following:
  - per-axis sync polarity;
  - pixel clock-enable for divided pixel rates;
  - a prefetch coordinate stream running C_prefetch pixels ahead, for framebuffer/SDRAM readers;
  - line/frame strobes and a frame counter.
- Outputs drive vga2dvid (hsync/vsync/blank) and the video fetch logic.

Parameters:
- C_resolution_x, 1024, active pixels per line
- C_hsync_front_porch, 16, pixels
- C_hsync_pulse, 96, pixels
- C_hsync_back_porch, 44, pixels
- C_resolution_y, 768, active lines
- C_vsync_front_porch, 10, lines
- C_vsync_pulse, 2, lines
- C_vsync_back_porch, 31, lines
- C_bits_x, 11, width of horizontal counters/coords
- C_bits_y, 11, width of vertical counters/coords
- C_hsync_polarity, 1'b0, active level of hsync (0 = active-low)
- C_vsync_polarity, 1'b0, active level of vsync
- C_prefetch, 2, fetch lead in pixels; legal range 0..(hfp+hpulse+hbp)
- C_frame_bits, 8, frame counter width

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- ce  in  1  pixel enable; state advances only when high
- x  out  C_bits_x  current horizontal position
- y  out  C_bits_y  current vertical position
- hsync  out  1  horizontal sync, polarity per parameter
- vsync  out  1  vertical sync, polarity per parameter
- blank  out  1  high outside the active area
- fetch_x  out  C_bits_x  x coordinate C_prefetch pixels ahead
- fetch_y  out  C_bits_y  y coordinate C_prefetch pixels ahead
- fetch_active  out  1  fetch coordinate lies in the active area
- line_start  out  1  1-cycle pulse at x=0
- frame_start  out  1  1-cycle pulse at x=0, y=0
- frame_count  out  C_frame_bits  completed-frame counter
- test_r / test_g / test_b  out  8 each  test picture (see Optional Feature)

Behaviour:
- htotal = X + hfp + hpulse + hbp; vtotal likewise.
- Horizontal segment order:
  - active: 0..X-1
  - front porch: X..X+hfp-1
  - sync: X+hfp..X+hfp+hpulse-1
  - back porch: remainder
- Vertical segment order is identical, per line.
- hcount increments on each ce cycle. At htotal-1 it wraps to 0 and vcount increments; vcount wraps at vtotal-1.
- Counters and outputs are all registered.
- Latency: outputs reflect counter state of the previous ce cycle, i.e. one ce cycle after the counter value.
- x, y, hsync, vsync, blank are mutually aligned.
- blank = (hcount >= X) or (vcount >= Y).
- vsync is evaluated on vcount only and changes together with the hcount=0 output.
- Fetch stream:
  - hf = hcount + C_prefetch; if hf >= htotal, then hf -= htotal and vf = vcount+1 (vf wraps at vtotal), else vf = vcount.
  - fetch_active = (hf < X) and (vf < Y).
  - fetch_x/fetch_y are registered with the same latency as x/y.
  - C_prefetch = 0 makes the fetch outputs equal x/y/~blank.
- Strobes:
  - line_start and frame_start are high only in the output cycle whose x=0 (and y=0 for frame_start).
  - They are forced low in any cycle where ce=0, so they never stretch.
- frame_count increments when vcount wraps from vtotal-1 to 0 and rolls over modulo 2^C_frame_bits.
- ce=0: counters and sync/blank/coordinate outputs hold.
- Reset values (asynchronous):
  - hcount = vcount = 0
  - x = y = fetch_x = fetch_y = 0
  - blank = 1, fetch_active = 0
  - hsync = ~C_hsync_polarity, vsync = ~C_vsync_polarity
  - strobes = 0, frame_count = 0, test_* = 0
- The first ce cycle after reset release presents hcount=0, vcount=0, so line_start = frame_start = 1.
- Reset mid-frame aborts immediately; no partial-frame completion.

Optional Feature:
- Macro: VGA_TIMING_TEST_PICTURE_EN.
- Defined:
  - test_r = x[7:0], test_g = y[7:0], test_b = frame_count-derived 8-bit value (zero-extended or truncated to 8 bits).
  - A 1-pixel white border (255,255,255) at x=0, x=X-1, y=0, y=Y-1.
  - All test_* are 0 while blank.
  - Registered, aligned with blank.
- Undefined: test_r/g/b are tied to 0 and no test logic is synthesised.

Decomposition:
- Shared package vga_timing_pkg:
  - derived constants (htotal, vtotal, segment boundaries);
  - a default-mode localparam set for 1024x768 and 640x480.
- One natural sub-module: vga_axis_counter, a wrap counter with segment decode, instantiated for the horizontal and vertical axes.

Test Plan:
- Small mode X=8, hfp=2, hpulse=3, hbp=1, Y=4, vfp=1, vpulse=2, vbp=1, ce=1:
  - htotal = 14; hsync low for output x=10..12; blank high for x=8..13.
  - vsync low for y=5..6; frame_start pulses every 112 cycles.
- Same mode, C_prefetch=2:
  - at output x=12 (y=3): fetch_x=0, fetch_y=4, fetch_active=0;
  - at output x=13 (y=7): fetch_x=1, fetch_y=0, fetch_active=1.
- ce toggling 1010...: counters advance every other cycle; line_start pulses exactly 1 cycle wide; period 28 cycles.
- C_hsync_polarity=1, C_vsync_polarity=1: during reset hsync=vsync=0; pulses are active-high in the same positions as case 1.
- Reset asserted mid-line at x=5, y=2: outputs go to reset values asynchronously; first ce after release gives x=0, y=0, frame_start=1; frame_count=0.
- C_frame_bits=2, run 5 frames: frame_count sequence 1, 2, 3, 0, 1.
- With VGA_TIMING_TEST_PICTURE_EN: pixel (3,2) gives test_r=3, test_g=2; pixel (0,1) gives 255,255,255; pixel (9,0) gives test_* = 0.
